// File: rtl/wb_register_file_pkg.sv
// Shared constants and helpers for the write-back register file.
// Provides:
//   DATA_W, NUM_REGS  default register width and register count
//   IDX_W             register-index width
//   CNT_W             width of the pending-register count
//   ZERO_REG          index of the hardwired-zero register
//   popcount()        population count over the pending-bit vector
package wb_register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int CNT_W    = IDX_W + 1;

  localparam logic [IDX_W-1:0] ZERO_REG = '0;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/wb_register_file_if.sv
// Bus between the pipeline (decode + write-back stages) and the register file.
//   WB_*            write-back port: enable, destination index, data
//   ID_ReadReg1/2   decode source indices; ID_ReadData1/2 operand values
//   ID_MarkPending  decode issues a long-latency producer into ID_MarkReg
//   ID_Stall        a source operand still waits on its producer
//   Pending_Count   number of registers with an outstanding producer
// master = pipeline side, slave = register file.
interface wb_register_file_if #(
  parameter int DATA_W = wb_register_file_pkg::DATA_W
);
  import wb_register_file_pkg::*;

  logic              WB_RegWrite;
  logic [IDX_W-1:0]  WB_WriteReg;
  logic [DATA_W-1:0] WB_WriteData;
  logic [IDX_W-1:0]  ID_ReadReg1;
  logic [IDX_W-1:0]  ID_ReadReg2;
  logic [DATA_W-1:0] ID_ReadData1;
  logic [DATA_W-1:0] ID_ReadData2;
  logic              ID_MarkPending;
  logic [IDX_W-1:0]  ID_MarkReg;
  logic              ID_Stall;
  logic [CNT_W-1:0]  Pending_Count;

  modport master (
    output WB_RegWrite, WB_WriteReg, WB_WriteData,
    output ID_ReadReg1, ID_ReadReg2, ID_MarkPending, ID_MarkReg,
    input  ID_ReadData1, ID_ReadData2, ID_Stall, Pending_Count
  );

  modport slave (
    input  WB_RegWrite, WB_WriteReg, WB_WriteData,
    input  ID_ReadReg1, ID_ReadReg2, ID_MarkPending, ID_MarkReg,
    output ID_ReadData1, ID_ReadData2, ID_Stall, Pending_Count
  );

endinterface

// File: rtl/wb_register_file_pending_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set by decode when a
// long-latency producer issues, cleared when write-back retires it.
//   clk_i, rst_i         clock, async active-high reset
//   set_i, set_idx_i     mark a register pending
//   clr_i, clr_idx_i     write-back retiring a register
//   rd1/2_idx_i          decode source indices
//   byp1/2_i             that read port is served by the write-back bypass
//   stall_o              some unbypassed source is pending
//   count_o              registered popcount of the pending bits
module wb_register_file_pending_scoreboard
  import wb_register_file_pkg::*;
#(
  parameter int NUM_REGS = wb_register_file_pkg::NUM_REGS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic [IDX_W-1:0] rd1_idx_i,
  input  logic [IDX_W-1:0] rd2_idx_i,
  input  logic             byp1_i,
  input  logic             byp2_i,
  output logic             stall_o,
  output logic [CNT_W-1:0] count_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q;

  // Clear first, then set: a new producer on the same index supersedes
  // the one retiring this cycle.
  always_comb begin
    pend_d = pend_q;
    if (clr_i && clr_idx_i != ZERO_REG) pend_d[clr_idx_i] = 1'b0;
    if (set_i && set_idx_i != ZERO_REG) pend_d[set_idx_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Count is taken from the next-state bits so it lines up with them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= popcount(pend_d);
    end
  end

  logic hit1, hit2;
  assign hit1 = (rd1_idx_i != ZERO_REG) && pend_q[rd1_idx_i] && !byp1_i;
  assign hit2 = (rd2_idx_i != ZERO_REG) && pend_q[rd2_idx_i] && !byp2_i;

  assign stall_o = !rst_i && (hit1 || hit2);
  assign count_o = cnt_q;

endmodule

// File: rtl/wb_register_file.sv
// Two-read / one-write register file with write-through bypass and a
// pending-producer scoreboard for long-latency results (loads, SAD).
//   Clk    rising-edge clock
//   Reset  async active-high; clears storage, pending bits and count
//   bus    wb_register_file_if.slave (write-back, read, mark, stall, count)
// Register 0 reads as zero and is never written or marked.
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W   = wb_register_file_pkg::DATA_W,
  parameter int NUM_REGS = wb_register_file_pkg::NUM_REGS
) (
  input  logic               Clk,
  input  logic               Reset,
  wb_register_file_if.slave  bus
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic                            wr_en;

  assign wr_en = bus.WB_RegWrite && (bus.WB_WriteReg != ZERO_REG);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)      regs_q <= '0;
    else if (wr_en) regs_q[bus.WB_WriteReg] <= bus.WB_WriteData;
  end

  // Bypass is held off during reset so reads show the cleared storage.
  logic byp1, byp2;
  assign byp1 = !Reset && wr_en && (bus.WB_WriteReg == bus.ID_ReadReg1);
  assign byp2 = !Reset && wr_en && (bus.WB_WriteReg == bus.ID_ReadReg2);

  assign bus.ID_ReadData1 = (bus.ID_ReadReg1 == ZERO_REG) ? '0 :
                            byp1 ? bus.WB_WriteData : regs_q[bus.ID_ReadReg1];
  assign bus.ID_ReadData2 = (bus.ID_ReadReg2 == ZERO_REG) ? '0 :
                            byp2 ? bus.WB_WriteData : regs_q[bus.ID_ReadReg2];

  wb_register_file_pending_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .set_i     (bus.ID_MarkPending),
    .set_idx_i (bus.ID_MarkReg),
    .clr_i     (bus.WB_RegWrite),
    .clr_idx_i (bus.WB_WriteReg),
    .rd1_idx_i (bus.ID_ReadReg1),
    .rd2_idx_i (bus.ID_ReadReg2),
    .byp1_i    (byp1),
    .byp2_i    (byp2),
    .stall_o   (bus.ID_Stall),
    .count_o   (bus.Pending_Count)
  );

endmodule
